ama_riscv_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the AMA-RISCV core; it generalises the single-PC IF stage into a decoupled fetcher with a configurable-depth fetch queue. It owns the fetch PC, issues reads to the synchronous IMEM, tags each returned instruction with its PC, and hands instructions to ID over a valid/ready handshake. Redirects (branch, jump, or start address) flush the queue and discard the in-flight IMEM response.

---
 rtl/ama_riscv_fetch_unit_if.sv | 28 ++
 rtl/ama_riscv_fetch_unit.sv | 103 ++++++++++
 tb/tb_ama_riscv_fetch_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ama_riscv_fetch_unit_if.sv
// Fetch-unit bundle: redirect input, synchronous IMEM port, and the ID-facing instruction handshake.
interface ama_riscv_fetch_unit_if #(
   parameter int unsigned FQ_DEPTH = 4,
   parameter int unsigned IMEM_AW  = 14
);
   localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               imem_req;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic               inst_valid;
   logic               inst_ready;
   logic [31:0]        inst;
   logic [31:0]        inst_pc;
   logic [CNT_W-1:0]   fq_count;

   modport master (
      input  redirect_valid, redirect_pc, imem_rdata, inst_ready,
      output imem_req, imem_addr, inst_valid, inst, inst_pc, fq_count
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_rdata, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst, inst_pc, fq_count
   );
endinterface

// File: rtl/ama_riscv_fetch_unit.sv
// Decoupled instruction fetcher: owns the fetch PC, issues IMEM reads under a credit limit and
// buffers tagged instructions in a circular queue; redirects flush the queue and the in-flight read.
module ama_riscv_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0,
   parameter int unsigned FQ_DEPTH     = 4,
   parameter int unsigned IMEM_AW      = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   ama_riscv_fetch_unit_if.master  fif
);
   localparam int unsigned PTR_W  = $clog2(FQ_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned CRED_W = CNT_W + 1;
   localparam logic [31:0]       NOP        = 32'h0000_0013;
   localparam logic [CRED_W-1:0] CREDIT_MAX = CRED_W'(FQ_DEPTH);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      resp_pc_q, resp_pc_d;
   logic             resp_pending_q, resp_pending_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [31:0] q_inst [FQ_DEPTH];
   logic [31:0] q_pc   [FQ_DEPTH];

   logic [31:0]       issue_pc;
   logic [CRED_W-1:0] credit;
   logic              req, push, pop, valid;

   // Issue/push/pop decisions and next-state for PC, response tracking and queue pointers.
   always_comb begin
      issue_pc = fif.redirect_valid ? (fif.redirect_pc & 32'hFFFF_FFFC) : fetch_pc_q;
      credit   = CRED_W'(count_q) + CRED_W'(resp_pending_q);
      req      = !rst && (fif.redirect_valid || (credit < CREDIT_MAX));
      valid    = !rst && (count_q != '0) && !fif.redirect_valid;
      push     = resp_pending_q && !fif.redirect_valid;
      pop      = valid && fif.inst_ready;

      fetch_pc_d     = fetch_pc_q;
      resp_pc_d      = resp_pc_q;
      resp_pending_d = 1'b0;
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      count_d        = count_q;

      if (req) begin
         fetch_pc_d     = issue_pc + 32'd4;
         resp_pending_d = 1'b1;
         resp_pc_d      = issue_pc;
      end

      // A redirect drops the response arriving now and empties the queue.
      if (fif.redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q     <= RESET_VECTOR;
         resp_pc_q      <= RESET_VECTOR;
         resp_pending_q <= 1'b0;
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
      end else begin
         fetch_pc_q     <= fetch_pc_d;
         resp_pc_q      <= resp_pc_d;
         resp_pending_q <= resp_pending_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
      end
   end

   // Queue storage is not reset; occupancy tracking alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         q_inst[wr_ptr_q] <= fif.imem_rdata;
         q_pc[wr_ptr_q]   <= resp_pc_q;
      end
   end

   assign fif.imem_req   = req;
   assign fif.imem_addr  = issue_pc[IMEM_AW+1:2];
   assign fif.inst_valid = valid;
   assign fif.inst       = valid ? q_inst[rd_ptr_q] : NOP;
   assign fif.inst_pc    = valid ? q_pc[rd_ptr_q] : 32'h0;
   assign fif.fq_count   = rst ? '0 : count_q;

endmodule

// File: tb/tb_ama_riscv_fetch_unit.sv
// Directed bench for ama_riscv_fetch_unit: reset fetch, redirects, PC wrap, backpressure, mid-run reset.
module tb_ama_riscv_fetch_unit;
   localparam int unsigned FQ_DEPTH = 4;
   localparam int unsigned IMEM_AW  = 14;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ama_riscv_fetch_unit_if #(.FQ_DEPTH(FQ_DEPTH), .IMEM_AW(IMEM_AW)) fif ();

   ama_riscv_fetch_unit #(
      .RESET_VECTOR(32'h0),
      .FQ_DEPTH    (FQ_DEPTH),
      .IMEM_AW     (IMEM_AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fif(fif.master)
   );

   // Synchronous IMEM: data is a marker plus the word address, one cycle after the request.
   always @(posedge clk) begin
      if (fif.imem_req) fif.imem_rdata <= 32'hA000_0000 | 32'(fif.imem_addr);
   end

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return 32'hA000_0000 | {18'b0, pc[15:2]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, 32'(fif.inst_valid), 32'd1);
      chk({tag, "_pc"}, fif.inst_pc, pc);
      chk({tag, "_inst"}, fif.inst, word_of(pc));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 32'(fif.inst_valid), 32'd0);
      chk({tag, "_inst"}, fif.inst, NOP);
      chk({tag, "_pc"}, fif.inst_pc, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nreq;
      int bp_cnt [8] = '{0, 0, 1, 2, 3, 4, 4, 4};
      int bp_req [8] = '{1, 1, 1, 1, 0, 0, 0, 0};

      fif.redirect_valid = 1'b0;
      fif.redirect_pc    = 32'h0;
      fif.inst_ready     = 1'b0;

      // Outputs while in reset
      tick(); rst = 1'b1; fif.inst_ready = 1'b1; settle();
      chk("rst_req", 32'(fif.imem_req), 32'd0);
      chk("rst_cnt", 32'(fif.fq_count), 32'd0);
      chk_idle("rst");

      // Reset fetch with ID always ready
      tick(); rst = 1'b0; settle();
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin tick(); settle(); end
         chk("rf_req", 32'(fif.imem_req), 32'd1);
         chk("rf_addr", 32'(fif.imem_addr), 32'(k));
         if (k >= 2) begin
            chk_head("rf_head", 32'((k - 2) * 4));
            chk("rf_cnt", 32'(fif.fq_count), 32'd1);
         end else begin
            chk_idle("rf_early");
         end
      end

      // Redirect mid-stream to 0x100
      tick(); fif.redirect_valid = 1'b1; fif.redirect_pc = 32'h100; settle();
      chk("rd_addr", 32'(fif.imem_addr), 32'h40);
      chk("rd_req", 32'(fif.imem_req), 32'd1);
      chk_idle("rd_r0");
      tick(); fif.redirect_valid = 1'b0; settle();
      chk("rd_addr1", 32'(fif.imem_addr), 32'h41);
      chk_idle("rd_r1");
      tick(); settle(); chk_head("rd_r2", 32'h100);
      tick(); settle(); chk_head("rd_r3", 32'h104);

      // Back-to-back redirects, first one misaligned
      tick(); fif.redirect_valid = 1'b1; fif.redirect_pc = 32'h203; settle();
      chk("bb_addr0", 32'(fif.imem_addr), 32'h80);
      chk_idle("bb_r0");
      tick(); fif.redirect_pc = 32'h300; settle();
      chk("bb_addr1", 32'(fif.imem_addr), 32'hC0);
      chk_idle("bb_r1");
      tick(); fif.redirect_valid = 1'b0; settle();
      chk_idle("bb_r2");
      tick(); settle(); chk_head("bb_r3", 32'h300);
      tick(); settle(); chk_head("bb_r4", 32'h304);

      // PC wrap at the top of the address space
      tick(); fif.redirect_valid = 1'b1; fif.redirect_pc = 32'hFFFF_FFFC; settle();
      chk("wr_addr0", 32'(fif.imem_addr), 32'h3FFF);
      tick(); fif.redirect_valid = 1'b0; settle();
      chk("wr_addr1", 32'(fif.imem_addr), 32'h0);
      tick(); settle(); chk_head("wr_top", 32'hFFFF_FFFC);
      tick(); settle(); chk_head("wr_zero", 32'h0);
      tick(); settle(); chk_head("wr_four", 32'h4);

      // Backpressure from C0, then release
      tick(); rst = 1'b1; fif.inst_ready = 1'b0; settle();
      chk("bp_rst_req", 32'(fif.imem_req), 32'd0);
      tick(); rst = 1'b0; settle();
      nreq = 0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin tick(); settle(); end
         chk("bp_cnt", 32'(fif.fq_count), 32'(bp_cnt[k]));
         chk("bp_req", 32'(fif.imem_req), 32'(bp_req[k]));
         if (fif.imem_req) nreq++;
         if (k >= 2) chk_head("bp_hold", 32'h0);
      end
      chk("bp_nreq", 32'(nreq), 32'd4);
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 0) fif.inst_ready = 1'b1;
         settle();
         chk_head("bp_drain", 32'(k * 4));
         if (k == 0) begin
            chk("bp_rel_req", 32'(fif.imem_req), 32'd0);
            chk("bp_rel_cnt", 32'(fif.fq_count), 32'd4);
         end
         if (k == 1) begin
            chk("bp_refill_req", 32'(fif.imem_req), 32'd1);
            chk("bp_refill_addr", 32'(fif.imem_addr), 32'd4);
         end
      end

      // Reset with queued instructions and a response in flight
      tick(); rst = 1'b1; fif.inst_ready = 1'b0; settle();
      tick(); rst = 1'b0; settle();
      for (int k = 1; k < 5; k++) begin tick(); settle(); end
      chk("mr_pre_cnt", 32'(fif.fq_count), 32'd3);
      chk("mr_pre_req", 32'(fif.imem_req), 32'd0);
      tick(); rst = 1'b1; settle();
      chk("mr_in_req", 32'(fif.imem_req), 32'd0);
      chk("mr_in_cnt", 32'(fif.fq_count), 32'd0);
      chk_idle("mr_in");
      tick(); rst = 1'b0; settle();
      chk("mr_c0_cnt", 32'(fif.fq_count), 32'd0);
      chk("mr_c0_req", 32'(fif.imem_req), 32'd1);
      chk("mr_c0_addr", 32'(fif.imem_addr), 32'd0);
      chk_idle("mr_c0");
      tick(); settle();
      chk("mr_c1_cnt", 32'(fif.fq_count), 32'd0);
      chk_idle("mr_c1");
      tick(); fif.inst_ready = 1'b1; settle();
      chk_head("mr_c2", 32'h0);
      chk("mr_c2_cnt", 32'(fif.fq_count), 32'd1);
      tick(); settle();
      chk_head("mr_c3", 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
